run_sequencer: RTL and testbench

- Start/done sequencer between the bench-facing Start/Ack pins of TopLevel and the core's program counter.
- On each Start pulse it selects the next program (P1, P2, P3, then wraps), loads that program's entry address into the PC, and enables the core.
- It then waits for the core's halt indication and raises Ack.
- It also reports the cycle count of the last run for performance display.

---
 rtl/run_seq_pkg.sv | 29 ++
 rtl/sat_counter.sv | 30 +++
 rtl/run_sequencer.sv | 167 ++++++++++++++++
 tb/tb_run_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer: FSM state encoding,
// number of sequenced programs and the program entry-address table.
package run_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int NUM_PROG = 3;
  localparam int BASE_W   = 10;

  // Entry address of each program in instruction memory.
  localparam logic [BASE_W-1:0] BASE [NUM_PROG] = '{10'd0, 10'd128, 10'd256};

  // Entry address lookup; an out-of-range index falls back to program 0.
  function automatic logic [BASE_W-1:0] base_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    base_addr = BASE[0];
      2'd1:    base_addr = BASE[1];
      2'd2:    base_addr = BASE[2];
      default: base_addr = BASE[0];
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Used to measure how many cycles a program spends running.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: clear has priority over enable; holds at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/run_sequencer.sv
// Start/done sequencer: on each Start pulse (launch on its falling edge)
// selects the next program, pulses PCLoad with its entry address, enables
// the core until Halt retires, then raises Ack and reports the cycle count.
// Optional watchdog: define RUN_SEQUENCER_WATCHDOG_EN to force DONE after
// TIMEOUT run cycles without a Halt (Timeout output set).
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int               PC_W    = 10,
  parameter int               CYC_W   = 16,
  parameter logic [CYC_W-1:0] TIMEOUT = 16'hFFF0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  output logic             PCLoad,
  output logic [PC_W-1:0]  StartAddr,
  output logic             CoreEn,
  output logic             Ack,
  output logic [1:0]       ProgIdx,
  output logic [CYC_W-1:0] CycleCount,
  output logic             Timeout
);

  state_t            state_r, next_state_s;
  logic              pc_load_r, pc_load_s;
  logic [PC_W-1:0]   start_addr_r, start_addr_s;
  logic              core_en_r, core_en_s;
  logic              ack_r, ack_s;
  logic [1:0]        prog_idx_r, prog_idx_s;
  logic              timeout_r, timeout_s;
  logic              cnt_clr_s, cnt_en_s;
  logic [CYC_W-1:0]  cycle_count_s;
  logic [1:0]        prog_idx_inc_s;

  // Next program index, wrapping after the last program.
  always_comb begin
    if (prog_idx_r == 2'(NUM_PROG - 1)) begin
      prog_idx_inc_s = 2'd0;
    end else begin
      prog_idx_inc_s = prog_idx_r + 2'd1;
    end
  end

`ifndef RUN_SEQUENCER_WATCHDOG_EN
  // Watchdog disabled: the limit has no effect on behaviour.
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT;
`endif

  // FSM next-state and next-output decode.
  always_comb begin
    next_state_s = state_r;
    pc_load_s    = 1'b0;
    start_addr_s = start_addr_r;
    core_en_s    = core_en_r;
    ack_s        = ack_r;
    prog_idx_s   = prog_idx_r;
    timeout_s    = timeout_r;
    cnt_clr_s    = 1'b0;
    cnt_en_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (Start) begin
          next_state_s = ARMED;
          ack_s        = 1'b0;
        end else begin
          next_state_s = state_r;
        end
      end
      ARMED: begin
        if (Start) begin
          next_state_s = ARMED;
        end else begin
          next_state_s = LOAD;
          pc_load_s    = 1'b1;
          start_addr_s = PC_W'(base_addr(prog_idx_r));
          cnt_clr_s    = 1'b1;
          timeout_s    = 1'b0;
        end
      end
      LOAD: begin
        next_state_s = RUN;
        core_en_s    = 1'b1;
      end
      RUN: begin
        cnt_en_s = 1'b1;
        if (Halt) begin
          next_state_s = DONE;
          core_en_s    = 1'b0;
          ack_s        = 1'b1;
          prog_idx_s   = prog_idx_inc_s;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
        end else if (cycle_count_s == (TIMEOUT - CYC_W'(1))) begin
          next_state_s = DONE;
          core_en_s    = 1'b0;
          ack_s        = 1'b1;
          timeout_s    = 1'b1;
          prog_idx_s   = prog_idx_inc_s;
`endif
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        next_state_s = IDLE;
        core_en_s    = 1'b0;
        ack_s        = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered outputs; reset discards any run in progress.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_load_r    <= 1'b0;
      start_addr_r <= PC_W'(BASE[0]);
      core_en_r    <= 1'b0;
      ack_r        <= 1'b0;
      prog_idx_r   <= 2'd0;
      timeout_r    <= 1'b0;
    end else begin
      pc_load_r    <= pc_load_s;
      start_addr_r <= start_addr_s;
      core_en_r    <= core_en_s;
      ack_r        <= ack_s;
      prog_idx_r   <= prog_idx_s;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
      timeout_r    <= timeout_s;
`else
      timeout_r    <= 1'b0;
`endif
    end
  end

  sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk   (Clk),
    .reset (Reset),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .count (cycle_count_s)
  );

`ifndef RUN_SEQUENCER_WATCHDOG_EN
  logic unused_timeout_next_s;
  assign unused_timeout_next_s = timeout_s;
`endif

  assign PCLoad     = pc_load_r;
  assign StartAddr  = start_addr_r;
  assign CoreEn     = core_en_r;
  assign Ack        = ack_r;
  assign ProgIdx    = prog_idx_r;
  assign CycleCount = cycle_count_s;
  assign Timeout    = timeout_r;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer.
module tb_run_sequencer;

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  localparam logic [15:0] TB_TIMEOUT = 16'd100;
`else
  localparam logic [15:0] TB_TIMEOUT = 16'hFFF0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, halt;
  logic        pc_load, core_en, ack, timeout;
  logic [9:0]  start_addr;
  logic [1:0]  prog_idx;
  logic [15:0] cycle_count;

  int check_count = 0;
  int fail_count  = 0;
  int exp_idx     = 0;

  run_sequencer #(.PC_W(10), .CYC_W(16), .TIMEOUT(TB_TIMEOUT)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .Start      (start),
    .Halt       (halt),
    .PCLoad     (pc_load),
    .StartAddr  (start_addr),
    .CoreEn     (core_en),
    .Ack        (ack),
    .ProgIdx    (prog_idx),
    .CycleCount (cycle_count),
    .Timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_addr(input int idx);
    logic [31:0] a;
    a = 32'(idx) * 32'd128;
    return a;
  endfunction

  // Start high one cycle then low; checks Ack drop, PCLoad pulse, CoreEn.
  task automatic start_pulse();
    start = 1'b1;
    tick();
    check_eq("ack_clr", {31'd0, ack}, 32'd0);
    start = 1'b0;
    tick();
    check_eq("pcload_on", {31'd0, pc_load}, 32'd1);
    check_eq("start_addr", {22'd0, start_addr}, exp_addr(exp_idx));
    tick();
    check_eq("pcload_off", {31'd0, pc_load}, 32'd0);
    check_eq("core_en_on", {31'd0, core_en}, 32'd1);
    check_eq("cnt_zero", {16'd0, cycle_count}, 32'd0);
  endtask

  // Let the core run n cycles, Halt on the last one, check DONE outputs.
  task automatic run_halt(input int n);
    repeat (n - 1) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    exp_idx = (exp_idx == 2) ? 0 : exp_idx + 1;
    check_eq("ack_set", {31'd0, ack}, 32'd1);
    check_eq("core_en_off", {31'd0, core_en}, 32'd0);
    check_eq("cycles", {16'd0, cycle_count}, 32'(n));
    check_eq("prog_idx", {30'd0, prog_idx}, 32'(exp_idx));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    halt  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("rst_ack", {31'd0, ack}, 32'd0);
    check_eq("rst_core_en", {31'd0, core_en}, 32'd0);
    check_eq("rst_prog_idx", {30'd0, prog_idx}, 32'd0);
    check_eq("rst_cycles", {16'd0, cycle_count}, 32'd0);
    check_eq("rst_start_addr", {22'd0, start_addr}, 32'd0);
    check_eq("rst_pcload", {31'd0, pc_load}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);

    // Halt while idle is ignored.
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("idle_halt_ack", {31'd0, ack}, 32'd0);
    check_eq("idle_halt_core", {31'd0, core_en}, 32'd0);

    // Single run of 50 cycles, then DONE holds.
    start_pulse();
    run_halt(50);
    tick();
    tick();
    check_eq("done_hold_cnt", {16'd0, cycle_count}, 32'd50);
    check_eq("done_hold_ack", {31'd0, ack}, 32'd1);

    // Three back-to-back launches from reset: 0, 128, 256, then wrap.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    exp_idx = 0;
    for (int i = 0; i < 3; i++) begin
      start_pulse();
      run_halt(i * 5 + 1);
    end

    // Start held for 5 cycles in DONE: single launch only after the fall.
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("held_no_load", {31'd0, pc_load}, 32'd0);
    end
    check_eq("held_ack_low", {31'd0, ack}, 32'd0);
    start = 1'b0;
    tick();
    check_eq("held_load", {31'd0, pc_load}, 32'd1);
    check_eq("held_addr", {22'd0, start_addr}, exp_addr(exp_idx));
    // Start and Halt during LOAD are ignored.
    start = 1'b1;
    halt  = 1'b1;
    tick();
    check_eq("load_ign_core", {31'd0, core_en}, 32'd1);
    check_eq("load_ign_ack", {31'd0, ack}, 32'd0);
    check_eq("load_ign_pcl", {31'd0, pc_load}, 32'd0);
    halt = 1'b0;
    // Start during RUN is ignored.
    tick();
    check_eq("run_ign_start", {31'd0, core_en}, 32'd1);
    check_eq("run_ign_pcl", {31'd0, pc_load}, 32'd0);
    // Halt and Start together: Halt wins, then Start still high -> ARMED.
    halt = 1'b1;
    tick();
    halt = 1'b0;
    exp_idx = 1;
    check_eq("hs_ack", {31'd0, ack}, 32'd1);
    check_eq("hs_cycles", {16'd0, cycle_count}, 32'd2);
    check_eq("hs_idx", {30'd0, prog_idx}, 32'd1);
    tick();
    check_eq("hs_armed_ack", {31'd0, ack}, 32'd0);
    start = 1'b0;
    tick();
    check_eq("hs_load", {31'd0, pc_load}, 32'd1);
    check_eq("hs_addr", {22'd0, start_addr}, 32'd128);
    tick();
    check_eq("hs_run", {31'd0, core_en}, 32'd1);

    // Reset in the middle of a run at cycle 20.
    repeat (20) tick();
    check_eq("mid_cycles", {16'd0, cycle_count}, 32'd20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_core", {31'd0, core_en}, 32'd0);
    check_eq("mid_rst_ack", {31'd0, ack}, 32'd0);
    check_eq("mid_rst_idx", {30'd0, prog_idx}, 32'd0);
    exp_idx = 0;
    start_pulse();
    run_halt(3);

    // No Halt: watchdog ends the run, or the counter saturates.
    start_pulse();
`ifdef RUN_SEQUENCER_WATCHDOG_EN
    repeat (99) tick();
    check_eq("wd_still_run", {31'd0, core_en}, 32'd1);
    tick();
    check_eq("wd_timeout", {31'd0, timeout}, 32'd1);
    check_eq("wd_ack", {31'd0, ack}, 32'd1);
    check_eq("wd_core_off", {31'd0, core_en}, 32'd0);
    check_eq("wd_cycles", {16'd0, cycle_count}, 32'd100);
    check_eq("wd_idx", {30'd0, prog_idx}, 32'd2);
    start_pulse();
    check_eq("wd_timeout_clr", {31'd0, timeout}, 32'd0);
`else
    repeat (65540) tick();
    check_eq("sat_core", {31'd0, core_en}, 32'd1);
    check_eq("sat_cycles", {16'd0, cycle_count}, 32'hFFFF);
    check_eq("sat_ack", {31'd0, ack}, 32'd0);
    check_eq("sat_timeout", {31'd0, timeout}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
